// File: rtl/regfile_scan_ctrl_pkg.sv
// Shared definitions for the regfile scan sequencer: default geometry, mode codes, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_scan_ctrl_pkg;

    // Default regfile geometry; r0 is hardwired to zero so FILL starts at r1.
    localparam int REG_NUM      = 32;
    localparam int REG_ADDR_W   = 5;
    localparam int REG_DATA_W   = 32;
    localparam int REG_FIRST_WR = 1;

    // Operation select, sampled together with start.
    localparam logic MODE_DUMP = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DUMP = 2'd2,
        ST_DONE = 2'd3
    } scan_state_t;

endpackage

// File: rtl/regfile_scan_ctrl.sv
// Regfile bring-up sequencer: FILL writes base+addr into every register, DUMP streams {addr,data} beats.
// Latency: FILL writes from start+1, done at start+NREG-FIRST_WR+1; DUMP first beat at start+2, done at start+NREG+2.
// Backpressure: FILL ignores it; DUMP holds a single output register stable while o_out_valid && !i_out_ready.
//
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_start, i_mode, i_fill_base   request pulse, 0=DUMP/1=FILL, FILL pattern base (sampled in IDLE only)
//   o_busy, o_done            state != IDLE, one-cycle completion pulse
//   o_rf_wen/o_rf_waddr/o_rf_wdata   regfile synchronous write port
//   o_rf_test_addr/i_rf_test_data    regfile asynchronous debug read port
//   o_out_valid/i_out_ready/o_out_addr/o_out_data   dump beat stream
module regfile_scan_ctrl
    import regfile_scan_ctrl_pkg::*;
#(
    parameter int NREG     = REG_NUM,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int DATA_W   = REG_DATA_W,
    parameter int FIRST_WR = REG_FIRST_WR
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_mode,
    input  logic [DATA_W-1:0] i_fill_base,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_rf_wen,
    output logic [ADDR_W-1:0] o_rf_waddr,
    output logic [DATA_W-1:0] o_rf_wdata,
    output logic [ADDR_W-1:0] o_rf_test_addr,
    input  logic [DATA_W-1:0] i_rf_test_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [ADDR_W-1:0] o_out_addr,
    output logic [DATA_W-1:0] o_out_data
);

    // One extra index bit so a full 2**ADDR_W sweep can reach NREG without wrapping.
    localparam int IDX_W = ADDR_W + 1;
    localparam logic [IDX_W-1:0] LP_NREG  = IDX_W'(NREG);
    localparam logic [IDX_W-1:0] LP_LAST  = IDX_W'(NREG - 1);
    localparam logic [IDX_W-1:0] LP_FIRST = IDX_W'(FIRST_WR);

    scan_state_t       r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_base;
    logic              r_busy;
    logic              r_done;
    logic              r_rf_wen;
    logic [ADDR_W-1:0] r_rf_waddr;
    logic [DATA_W-1:0] r_rf_wdata;
    logic              r_out_valid;
    logic [ADDR_W-1:0] r_out_addr;
    logic [DATA_W-1:0] r_out_data;

    logic [IDX_W-1:0]  w_idx_nxt;
    logic              w_fetch;
    logic              w_accept;
    logic              w_load;
    logic              w_last_beat;

    assign w_idx_nxt   = r_idx + IDX_W'(1);
    // In DUMP, r_idx is the fetch pointer: a read is still owed while it is below NREG.
    assign w_fetch     = (r_idx < LP_NREG);
    assign w_accept    = r_out_valid && i_out_ready;
    // The output register refills when empty or being drained this cycle, giving one beat per cycle.
    assign w_load      = w_fetch && (!r_out_valid || i_out_ready);
    assign w_last_beat = w_accept && (r_out_addr == LP_LAST[ADDR_W-1:0]);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_base      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rf_wen    <= 1'b0;
            r_rf_waddr  <= '0;
            r_rf_wdata  <= '0;
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_busy <= 1'b1;
                        r_base <= i_fill_base;
                        if (i_mode == MODE_FILL) begin
                            // First write is presented in the very next cycle.
                            r_state    <= ST_FILL;
                            r_idx      <= LP_FIRST;
                            r_rf_wen   <= 1'b1;
                            r_rf_waddr <= LP_FIRST[ADDR_W-1:0];
                            r_rf_wdata <= i_fill_base + DATA_W'(LP_FIRST);
                        end else begin
                            r_state <= ST_DUMP;
                            r_idx   <= '0;
                        end
                    end
                end
                ST_FILL: begin
                    if (r_idx == LP_LAST) begin
                        r_state  <= ST_DONE;
                        r_rf_wen <= 1'b0;
                        r_done   <= 1'b1;
                    end else begin
                        r_idx      <= w_idx_nxt;
                        r_rf_waddr <= w_idx_nxt[ADDR_W-1:0];
                        r_rf_wdata <= r_base + DATA_W'(w_idx_nxt);
                    end
                end
                ST_DUMP: begin
                    if (w_load) begin
                        r_out_valid <= 1'b1;
                        r_out_addr  <= r_idx[ADDR_W-1:0];
                        r_out_data  <= i_rf_test_data;
                        r_idx       <= w_idx_nxt;
                    end else if (w_accept) begin
                        r_out_valid <= 1'b0;
                    end
                    // Fetch is exhausted by the time the last beat drains, so valid drops above.
                    if (w_last_beat) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_idx   <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_rf_wen       = r_rf_wen;
    assign o_rf_waddr     = r_rf_waddr;
    assign o_rf_wdata     = r_rf_wdata;
    // Debug read address follows the fetch pointer only while dumping; parked at 0 otherwise.
    assign o_rf_test_addr = (r_state == ST_DUMP) ? r_idx[ADDR_W-1:0] : '0;
    assign o_out_valid    = r_out_valid;
    assign o_out_addr     = r_out_addr;
    assign o_out_data     = r_out_data;

endmodule

// File: tb/tb_regfile_scan_ctrl.sv
module tb_regfile_scan_ctrl;
    import regfile_scan_ctrl_pkg::*;

    localparam int NREG = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [31:0] fill_base = '0;
    logic        out_ready = 1'b0;
    logic        rf_init = 1'b1;

    logic        busy, done, rf_wen, out_valid;
    logic [4:0]  rf_waddr, rf_test_addr, out_addr;
    logic [31:0] rf_wdata, rf_test_data, out_data;

    always #5 clk = ~clk;

    regfile_scan_ctrl #(.NREG(32), .ADDR_W(5), .DATA_W(32), .FIRST_WR(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode), .i_fill_base(fill_base),
        .o_busy(busy), .o_done(done),
        .o_rf_wen(rf_wen), .o_rf_waddr(rf_waddr), .o_rf_wdata(rf_wdata),
        .o_rf_test_addr(rf_test_addr), .i_rf_test_data(rf_test_data),
        .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_addr(out_addr), .o_out_data(out_data)
    );

    // Regfile: sync write, async read, r0 reads zero.
    logic [31:0] rf [NREG];
    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < NREG; i++) rf[i] <= 32'hC0DE_0000 | 32'(i);
        end else if (rf_wen && rf_waddr != 5'd0) begin
            rf[rf_waddr] <= rf_wdata;
        end
    end
    assign rf_test_data = (rf_test_addr == 5'd0) ? 32'd0 : rf[rf_test_addr];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    logic [36:0] wq [$];
    logic [36:0] bq [$];
    logic [31:0] exp_rf [NREG];
    logic [31:0] cap [NREG];

    // Monitor: pops expected writes/beats when the DUT presents them.
    logic        stall_prev = 1'b0;
    logic [4:0]  h_addr;
    logic [31:0] h_data;
    logic [36:0] m_exp;
    always @(negedge clk) begin
        if (rf_wen === 1'b1) begin
            if (wq.size() == 0) begin
                checks++; failures++;
                $display("FAIL write_unexpected actual=%h required=none", {rf_waddr, rf_wdata});
            end else begin
                m_exp = wq.pop_front();
                chk("write", 64'({rf_waddr, rf_wdata}), 64'(m_exp));
            end
        end
        if (stall_prev)
            chk("stall_hold", 64'({out_valid, out_addr, out_data}), 64'({1'b1, h_addr, h_data}));
        if (out_valid === 1'b1 && out_ready) begin
            if (bq.size() == 0) begin
                checks++; failures++;
                $display("FAIL beat_unexpected actual=%h required=none", {out_addr, out_data});
            end else begin
                m_exp = bq.pop_front();
                chk("beat", 64'({out_addr, out_data}), 64'(m_exp));
            end
            cap[out_addr] = out_data;
        end
        stall_prev = (out_valid === 1'b1) && !out_ready && !rst;
        h_addr = out_addr;
        h_data = out_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive start for one cycle; returns in the first cycle after the request.
    task automatic issue(input logic m, input logic [31:0] b);
        start = 1'b1; mode = m; fill_base = b;
        tick();
        start = 1'b0;
    endtask

    task automatic do_fill(input logic [31:0] b, input int last);
        for (int i = 1; i <= last; i++) begin
            wq.push_back({5'(i), b + 32'(i)});
            exp_rf[i] = b + 32'(i);
        end
        issue(MODE_FILL, b);
    endtask

    task automatic do_dump();
        for (int i = 0; i < NREG; i++) begin
            bq.push_back({5'(i), exp_rf[i]});
            cap[i] = 'x;
        end
        issue(MODE_DUMP, 32'h0);
    endtask

    // Observe cycles t+1.. until done (bounded); optional stray start pulse mid-operation.
    task automatic run(input int rdy_mode, input int pulse_at, input logic pmode,
                       output int done_n, output int busy_n, output int wen_n,
                       output int vfirst, output int vld_n);
        done_n = -1; busy_n = 0; wen_n = 0; vfirst = -1; vld_n = 0;
        for (int n = 1; n <= 200; n++) begin
            start = (n == pulse_at);
            mode  = pmode;
            if (rdy_mode == 0)      out_ready = 1'b1;
            else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
            else                    out_ready = 1'b0;
            if (busy) busy_n++;
            if (rf_wen) wen_n++;
            if (out_valid && vfirst < 0) vfirst = n;
            if (out_valid && out_ready) vld_n++;
            if (done) begin
                done_n = n;
                break;
            end
            tick();
        end
        start = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctrl"}, 64'({busy, done, rf_wen, out_valid}), 64'(0));
        chk({tag, "_wport"}, 64'({rf_waddr, rf_wdata}), 64'(0));
        chk({tag, "_taddr"}, 64'(rf_test_addr), 64'(0));
        chk({tag, "_out"}, 64'({out_addr, out_data}), 64'(0));
    endtask

    int dn, bn, wn, vf, vn;

    initial begin
        exp_rf[0] = 32'h0;
        for (int i = 1; i < NREG; i++) exp_rf[i] = 32'hC0DE_0000 | 32'(i);

        repeat (3) tick();
        chk_zero("reset");
        rst = 1'b0; rf_init = 1'b0;
        tick();

        // FILL base 0x1000_0000: writes r1..r31 at t+1..t+31, done at t+32.
        do_fill(32'h1000_0000, 31);
        run(0, 0, MODE_FILL, dn, bn, wn, vf, vn);
        chk("fill1_done_cycle", 64'(dn), 64'(32));
        chk("fill1_busy_cycles", 64'(bn), 64'(32));
        chk("fill1_wen_cycles", 64'(wn), 64'(31));
        tick();
        chk("fill1_idle", 64'({busy, done, rf_wen}), 64'(0));

        // DUMP, ready=1: beats t+2..t+33, done at t+34.
        do_dump();
        run(0, 0, MODE_DUMP, dn, bn, wn, vf, vn);
        chk("dump1_done_cycle", 64'(dn), 64'(34));
        chk("dump1_busy_cycles", 64'(bn), 64'(34));
        chk("dump1_first_beat", 64'(vf), 64'(2));
        chk("dump1_beats", 64'(vn), 64'(32));
        chk("dump1_r5", 64'(cap[5]), 64'(32'h1000_0005));
        chk("dump1_r0", 64'(cap[0]), 64'(0));
        chk("dump1_drained", 64'(bq.size()), 64'(0));
        tick();
        chk("dump1_idle", 64'({busy, done, rf_test_addr}), 64'(0));

        // FILL base 0xFFFF_FFF0 with a stray DUMP request mid-operation.
        do_fill(32'hFFFF_FFF0, 31);
        run(0, 10, MODE_DUMP, dn, bn, wn, vf, vn);
        chk("fill2_done_cycle", 64'(dn), 64'(32));
        chk("fill2_wen_cycles", 64'(wn), 64'(31));
        tick();
        chk("fill2_idle", 64'({busy, done, out_valid}), 64'(0));

        // DUMP with random ready and a stray FILL request mid-operation.
        do_dump();
        run(1, 5, MODE_FILL, dn, bn, wn, vf, vn);
        chk("dump2_beats", 64'(vn), 64'(32));
        chk("dump2_no_writes", 64'(wn), 64'(0));
        chk("dump2_r16_wrap", 64'(cap[16]), 64'(32'h0000_0000));
        chk("dump2_r31_wrap", 64'(cap[31]), 64'(32'h0000_000F));
        chk("dump2_drained", 64'(bq.size()), 64'(0));
        tick();
        chk("dump2_idle", 64'({busy, done}), 64'(0));

        // Reset mid-FILL while r9 is being written: r1..r9 new, r10+ untouched.
        do_fill(32'hA5A5_0000, 9);
        repeat (8) tick();
        chk("fillrst_at_r9", 64'({rf_wen, rf_waddr}), 64'({1'b1, 5'd9}));
        rst = 1'b1;
        tick();
        chk_zero("fillrst");
        rst = 1'b0;
        tick();
        chk("fillrst_writes_done", 64'(wq.size()), 64'(0));

        // Reset mid-DUMP with a beat stalled in the output register.
        out_ready = 1'b0;
        do_dump();
        for (int k = 0; k < 10 && out_valid !== 1'b1; k++) tick();
        chk("dumprst_stalled", 64'(out_valid), 64'(1));
        rst = 1'b1;
        tick();
        chk_zero("dumprst");
        rst = 1'b0;
        bq.delete();
        tick();

        // Fresh DUMP restarts at address 0 and shows the mixed contents.
        do_dump();
        run(0, 0, MODE_DUMP, dn, bn, wn, vf, vn);
        chk("dump3_done_cycle", 64'(dn), 64'(34));
        chk("dump3_beats", 64'(vn), 64'(32));
        chk("dump3_r0", 64'(cap[0]), 64'(0));
        chk("dump3_r9", 64'(cap[9]), 64'(32'hA5A5_0009));
        chk("dump3_r10", 64'(cap[10]), 64'(32'hFFFF_FFFA));
        chk("dump3_drained", 64'(bq.size()), 64'(0));
        tick();
        chk("final_idle", 64'({busy, done}), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
